// File: rtl/drm_data_pkg.sv
// Shared definitions for the drm_data RAM arbiter: default geometry,
// requester count, sequencer state encoding and the read-tag record.
package drm_data_pkg;

  localparam int ADDR_WIDTH = 12;
  localparam int DATA_WIDTH = 8;
  localparam int RD_LATENCY = 2;
  localparam int NUM_REQ    = 2;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  // One slot of the read-return pipeline: which requester the data belongs to.
  typedef struct packed {
    logic vld;
    logic id;
  } tag_t;

endpackage

// File: rtl/drm_data_rr_arb.sv
// Two-way round-robin grant. The grant is combinational; the pointer moves
// to the losing requester after every grant so contention alternates.
module drm_data_rr_arb
  import drm_data_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               en_i,
  input  logic [NUM_REQ-1:0] valid_i,
  output logic [NUM_REQ-1:0] grant_o
);

  logic rr_ptr_q, rr_ptr_d;

  always_comb begin
    grant_o = '0;
    if (en_i) begin
      unique case (valid_i)
        2'b01:   grant_o = 2'b01;
        2'b10:   grant_o = 2'b10;
        2'b11:   grant_o = rr_ptr_q ? 2'b10 : 2'b01;
        default: grant_o = '0;
      endcase
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_o[0]) begin
      rr_ptr_d = 1'b1;
    end else if (grant_o[1]) begin
      rr_ptr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/drm_data_arb.sv
// Owner of both drm_data RAM ports: zero-fill sweep after reset or on
// command, then one round-robin granted read or write per cycle.
//
//   state    | meaning
//   ST_CLEAR | writing 0 to clr_cnt each cycle, requesters held off
//   ST_RUN   | init_done=1, arbitration enabled, clear re-enters ST_CLEAR
module drm_data_arb #(
  parameter int ADDR_WIDTH = drm_data_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = drm_data_pkg::DATA_WIDTH,
  parameter int RD_LATENCY = drm_data_pkg::RD_LATENCY
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [1:0]              req_we,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  input  logic                    clear,
  output logic                    init_done,
  output logic                    ram_wr_en,
  output logic [ADDR_WIDTH-1:0]   ram_wr_addr,
  output logic [DATA_WIDTH-1:0]   ram_wr_data,
  output logic                    ram_wr_byte_en,
  output logic [ADDR_WIDTH-1:0]   ram_rd_addr,
  input  logic [DATA_WIDTH-1:0]   ram_rd_data
);
  import drm_data_pkg::*;

  localparam int PIPE_DEPTH = 1 + RD_LATENCY;
  localparam int CNT_W      = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] CLR_LAST = {1'b0, {ADDR_WIDTH{1'b1}}};

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       clr_cnt_q, clr_cnt_d;
  logic                   run;

  logic [NUM_REQ-1:0]     grant;
  logic                   win_id;
  logic                   win_we;
  logic [ADDR_WIDTH-1:0]  win_addr;
  logic [DATA_WIDTH-1:0]  win_wdata;

  logic                   wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]  wr_data_q, wr_data_d;
  logic [ADDR_WIDTH-1:0]  rd_addr_q, rd_addr_d;

  tag_t                   tag_in;
  tag_t [PIPE_DEPTH-1:0]  tag_q;
  tag_t                   tag_exit;

  // Sweep runs to the terminal address then hands over to RUN; a clear
  // request during the sweep has no effect.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    unique case (state_q)
      ST_CLEAR: begin
        if (clr_cnt_q == CLR_LAST) begin
          state_d   = ST_RUN;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (clear) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
        end
      end
      default: begin
        state_d   = ST_CLEAR;
        clr_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  assign run       = (state_q == ST_RUN);
  assign init_done = run;

  drm_data_rr_arb u_rr_arb (
    .clk     (clk),
    .rst     (rst),
    .en_i    (run),
    .valid_i (req_valid),
    .grant_o (grant)
  );

  assign req_ready = grant;

  assign win_id    = grant[1];
  assign win_we    = |(grant & req_we);
  assign win_addr  = win_id ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                            : req_addr[ADDR_WIDTH-1:0];
  assign win_wdata = win_id ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                            : req_wdata[DATA_WIDTH-1:0];

  // The sweep and granted commands share one registered write port.
  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rd_addr_d = rd_addr_q;
    if (!run) begin
      wr_en_d   = 1'b1;
      wr_addr_d = clr_cnt_q[ADDR_WIDTH-1:0];
      wr_data_d = '0;
    end else if (|grant) begin
      if (win_we) begin
        wr_en_d   = 1'b1;
        wr_addr_d = win_addr;
        wr_data_d = win_wdata;
      end else begin
        rd_addr_d = win_addr;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_addr_q <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  assign ram_wr_en      = wr_en_q;
  assign ram_wr_addr    = wr_addr_q;
  assign ram_wr_data    = wr_data_q;
  assign ram_wr_byte_en = 1'b1;
  assign ram_rd_addr    = rd_addr_q;

  // One slot for the address register plus RD_LATENCY for the RAM itself.
  assign tag_in.vld = run & (|grant) & ~win_we;
  assign tag_in.id  = win_id;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q <= '0;
    end else begin
      tag_q <= {tag_q[PIPE_DEPTH-2:0], tag_in};
    end
  end

  assign tag_exit  = tag_q[PIPE_DEPTH-1];
  assign rsp_valid = {tag_exit.vld & tag_exit.id, tag_exit.vld & ~tag_exit.id};
  assign rsp_rdata = tag_exit.vld ? ram_rd_data : '0;

endmodule
